// File: rtl/note_frame_accumulator_if.sv
// note_frame_accumulator_if: bin stream, visualizer handshake and status bundle
interface note_frame_accumulator_if #(
  parameter int W = 5,
  parameter int D = 11,
  parameter int BIN_QTY = 12,
  parameter int OCTAVES = 5
);
  localparam int AW = W + D;
  localparam int IW = $clog2(BIN_QTY * OCTAVES);
  logic bin_valid;
  logic [IW-1:0] bin_idx;
  logic [AW-1:0] bin_amp;
  logic frame_end;
  logic lv_done;
  logic [BIN_QTY-1:0][AW-1:0] amp_out;
  logic lv_start;
  logic busy;
  logic dropped;
  modport master (
    output bin_valid, bin_idx, bin_amp, frame_end, lv_done,
    input amp_out, lv_start, busy, dropped
  );
  modport slave (
    input bin_valid, bin_idx, bin_amp, frame_end, lv_done,
    output amp_out, lv_start, busy, dropped
  );
endinterface

// File: rtl/note_frame_accumulator.sv
// note_frame_accumulator: folds octave bins into note sums, IIR-smooths them per frame and hands
// a stable amplitude array to the visualizer. Optional macro PEAK_ATTACK_EN: instant attack on rise.
module note_frame_accumulator #(
  parameter int W = 5,
  parameter int D = 11,
  parameter int BIN_QTY = 12,
  parameter int OCTAVES = 5,
  parameter int DECAY_SHIFT = 2
) (
  input logic clk,
  input logic rst,
  note_frame_accumulator_if.slave bus
);
  localparam int AW = W + D;
  localparam int IW = $clog2(BIN_QTY * OCTAVES);
  localparam int NW = $clog2(BIN_QTY);
  localparam logic [AW-1:0] MAX = '1;
  typedef enum logic [1:0] {ACCUM, FILTER, ISSUE} state_t;
  state_t state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] sum_q [BIN_QTY];
  logic [AW-1:0] sum_d [BIN_QTY];
  logic [AW-1:0] filt_q [BIN_QTY];
  logic [AW-1:0] filt_d [BIN_QTY];
  logic [BIN_QTY-1:0][AW-1:0] amp_q, amp_d;
  logic lv_busy_q, lv_busy_d;
  logic dropped_q, dropped_d;
  logic start;
  logic in_range;
  logic [NW-1:0] note;
  logic [AW:0] acc;
  logic [AW-1:0] sat;
  logic signed [AW:0] diff;
  logic signed [AW+1:0] dx;
  logic signed [AW+1:0] nxt;
  logic [AW-1:0] clamped;
  assign note = NW'(bus.bin_idx % IW'(BIN_QTY));
  assign in_range = int'(bus.bin_idx) < BIN_QTY * OCTAVES;
  assign acc = {1'b0, sum_q[note]} + {1'b0, bus.bin_amp};
  assign sat = acc[AW] ? MAX : acc[AW-1:0];
  assign diff = $signed({1'b0, sum_q[cnt_q]}) - $signed({1'b0, filt_q[cnt_q]});
  assign dx = {diff[AW], diff};
  assign nxt = $signed({2'b00, filt_q[cnt_q]}) + (dx >>> DECAY_SHIFT);
  assign clamped = nxt[AW+1] ? '0 : (nxt[AW] ? MAX : nxt[AW-1:0]);
  assign start = (state_q == ISSUE) && (!lv_busy_q || bus.lv_done);
  assign bus.amp_out = amp_q;
  assign bus.lv_start = start;
  assign bus.busy = state_q != ACCUM;
  assign bus.dropped = dropped_q;
  // next-state: accumulate bins, filter one note per cycle, then wait for the visualizer
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    filt_d = filt_q;
    amp_d = amp_q;
    lv_busy_d = start | (lv_busy_q & ~bus.lv_done);
    dropped_d = dropped_q | ((state_q != ACCUM) & (bus.bin_valid | bus.frame_end));
    if (state_q == ACCUM) begin
      dropped_d = dropped_q | (bus.bin_valid & ~in_range);
      if (bus.bin_valid && in_range) sum_d[note] = sat;
      if (bus.frame_end) state_d = FILTER;
    end
    if (state_q == FILTER) begin
`ifdef PEAK_ATTACK_EN
      filt_d[cnt_q] = sum_q[cnt_q] > filt_q[cnt_q] ? sum_q[cnt_q] : clamped;
`else
      filt_d[cnt_q] = clamped;
`endif
      sum_d[cnt_q] = '0;
      cnt_d = cnt_q == NW'(BIN_QTY - 1) ? '0 : cnt_q + NW'(1);
      state_d = cnt_q == NW'(BIN_QTY - 1) ? ISSUE : FILTER;
    end
    if (start) begin
      for (int i = 0; i < BIN_QTY; i++) amp_d[i] = filt_q[i];
      state_d = ACCUM;
    end
  end
  // state, per-note storage and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
      cnt_q <= '0;
      amp_q <= '0;
      lv_busy_q <= 1'b0;
      dropped_q <= 1'b0;
      for (int i = 0; i < BIN_QTY; i++) begin
        sum_q[i] <= '0;
        filt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      amp_q <= amp_d;
      lv_busy_q <= lv_busy_d;
      dropped_q <= dropped_d;
      sum_q <= sum_d;
      filt_q <= filt_d;
    end
  end
endmodule

// File: tb/tb_note_frame_accumulator.sv
// tb_note_frame_accumulator: frame-level model plus directed frames with hand-computed results
module tb_note_frame_accumulator;
  localparam int NB = 12;
  localparam int NO = 5;
  localparam int MAXV = 65535;
  localparam int DS = 2;
`ifdef PEAK_ATTACK_EN
  localparam int L1 = 2048, L2 = 2048, L3 = 2048, L4A = 12, L4B = 1536, L5 = 65535, L28 = 100;
`else
  localparam int L1 = 512, L2 = 896, L3 = 1184, L4A = 3, L4B = 888, L5 = 16386, L28 = 25;
`endif
  logic clk = 0;
  logic rst = 1;
  note_frame_accumulator_if bus ();
  note_frame_accumulator dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int msum [NB];
  int mfilt [NB];
  int mamp [NB];
  bit inflight, mbusy, mdrop, lit_pending;
  int wcnt, cyc, fe_cyc, nstart, last0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int fdiv(input int d);
    int q = 1 << DS;
    return d >= 0 ? d / q : -((-d + q - 1) / q);
  endfunction
  // compare process: checks DUT against the frame model every cycle, then advances the model
  always @(negedge clk) begin
    bit es;
    int n, nf;
    cyc++;
    if (!rst) begin
      chk("rst_lv_start", bus.lv_start, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_dropped", bus.dropped, 0);
      for (int i = 0; i < NB; i++) chk($sformatf("rst_amp[%0d]", i), bus.amp_out[i], 0);
      for (int i = 0; i < NB; i++) begin
        msum[i] = 0;
        mfilt[i] = 0;
        mamp[i] = 0;
      end
      inflight = 0;
      mbusy = 0;
      mdrop = 0;
      wcnt = 0;
    end else begin
      es = inflight && wcnt == 0 && (!mbusy || bus.lv_done);
      chk("lv_start", bus.lv_start, int'(es));
      chk("busy", bus.busy, int'(inflight));
      chk("dropped", bus.dropped, int'(mdrop));
      for (int i = 0; i < NB; i++) chk($sformatf("amp[%0d]", i), bus.amp_out[i], mamp[i]);
      if (lit_pending) begin
        lit_pending = 0;
        case (nstart)
          1, 29: chk("lit_amp3_first", bus.amp_out[3], L1);
          2: chk("lit_amp3_second", bus.amp_out[3], L2);
          3: chk("lit_amp3_third", bus.amp_out[3], L3);
          4: begin
            chk("lit_amp0_small", bus.amp_out[0], L4A);
            chk("lit_amp3_decay", bus.amp_out[3], L4B);
          end
          5: chk("lit_amp0_sat", bus.amp_out[0], L5);
          28: begin
            chk("lit_dropped", bus.dropped, 1);
            chk("lit_amp5", bus.amp_out[5], L28);
          end
          default: ;
        endcase
        if (nstart >= 6 && nstart <= 25) chk("decay_monotone", int'(bus.amp_out[0] <= last0), 1);
        if (nstart >= 5 && nstart <= 25) last0 = bus.amp_out[0];
      end
      if (bus.lv_start) begin
        nstart++;
        lit_pending = 1;
        if (nstart == 1 || nstart == 29) chk("latency", cyc - fe_cyc, NB + 1);
      end
      if (!inflight) begin
        if (bus.bin_valid) begin
          if (bus.bin_idx >= NB * NO) mdrop = 1;
          else begin
            n = bus.bin_idx % NB;
            msum[n] = msum[n] + bus.bin_amp > MAXV ? MAXV : msum[n] + bus.bin_amp;
          end
        end
        if (bus.frame_end) begin
          for (int i = 0; i < NB; i++) begin
            nf = mfilt[i] + fdiv(msum[i] - mfilt[i]);
`ifdef PEAK_ATTACK_EN
            if (msum[i] > mfilt[i]) nf = msum[i];
`endif
            mfilt[i] = nf < 0 ? 0 : (nf > MAXV ? MAXV : nf);
            msum[i] = 0;
          end
          inflight = 1;
          wcnt = NB;
          fe_cyc = cyc;
        end
      end else begin
        if (bus.bin_valid || bus.frame_end) mdrop = 1;
        if (wcnt > 0) wcnt--;
        else if (es) begin
          mamp = mfilt;
          inflight = 0;
        end
      end
      mbusy = es ? 1 : (bus.lv_done ? 0 : mbusy);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bin(input int idx, input int amp);
    bus.bin_valid = 1;
    bus.bin_idx = 6'(idx);
    bus.bin_amp = 16'(amp);
    tick();
    bus.bin_valid = 0;
  endtask
  task automatic fe();
    bus.frame_end = 1;
    tick();
    bus.frame_end = 0;
  endtask
  task automatic wait_start();
    int n = 0;
    while (!bus.lv_start && n < 60) begin
      tick();
      n++;
    end
    if (!bus.lv_start) begin
      $display("FAIL start_timeout actual=no_lv_start required=lv_start");
      $fatal(1, "lv_start never arrived");
    end
    tick();
  endtask
  task automatic done_pulse();
    bus.lv_done = 1;
    tick();
    bus.lv_done = 0;
    tick();
  endtask
  task automatic std_frame();
    bin(3, 1024);
    bin(15, 1024);
    fe();
    wait_start();
  endtask
  initial begin
    bus.bin_valid = 0;
    bus.bin_idx = '0;
    bus.bin_amp = '0;
    bus.frame_end = 0;
    bus.lv_done = 0;
    #3 rst = 0;
    repeat (3) tick();
    rst = 1;
    tick();
    repeat (3) begin
      std_frame();
      done_pulse();
    end
    bin(0, 12);
    fe();
    wait_start();
    done_pulse();
    bin(0, 65535);
    bin(12, 65535);
    fe();
    wait_start();
    done_pulse();
    repeat (20) begin
      fe();
      wait_start();
      done_pulse();
    end
    std_frame();
    bin(3, 1024);
    bin(15, 1024);
    fe();
    repeat (25) tick();
    bus.lv_done = 1;
    tick();
    bus.lv_done = 0;
    tick();
    done_pulse();
    bin(60, 500);
    bin(5, 100);
    fe();
    bin(5, 1000);
    bus.bin_valid = 1;
    bus.frame_end = 1;
    tick();
    bus.bin_valid = 0;
    bus.frame_end = 0;
    wait_start();
    done_pulse();
    bin(3, 1024);
    bin(15, 1024);
    fe();
    repeat (4) tick();
    rst = 0;
    repeat (2) tick();
    rst = 1;
    tick();
    std_frame();
    done_pulse();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/note_frame_accumulator.md
Name: note_frame_accumulator

Overview:
- Upstream stage of the LED visualizer driver.
- Receives per-bin DFT amplitudes serially, one bin per valid cycle, across OCTAVES octaves.
- Folds the octaves into BIN_QTY note sums, applies per-note temporal smoothing once per frame, and presents a stable amplitude array to the visualizer.
- Pulses the visualizer's start only when the visualizer has signalled done for the previous frame.

Parameters:
- W, 5, whole bits of unsigned fixed-point amplitude
- D, 11, fractional bits (1.0 = 2048)
- BIN_QTY, 12, notes per octave / output lanes
- OCTAVES, 5, octaves folded per frame
- DECAY_SHIFT, 2, IIR smoothing shift; filtered moves 1/2^DECAY_SHIFT of the way to the new sum per frame

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- bin_valid  in  1  bin_amp/bin_idx valid this cycle
- bin_idx  in  $clog2(BIN_QTY*OCTAVES)  octave*BIN_QTY + note
- bin_amp  in  W+D  unsigned amplitude
- frame_end  in  1  single-cycle pulse: last bin of frame delivered
- lv_done  in  1  visualizer finished previous frame (pulse)
- amp_out  out  BIN_QTY x (W+D)  smoothed note amplitudes, stable between starts
- lv_start  out  1  single-cycle start pulse to visualizer
- busy  out  1  high in any state other than ACCUM
- dropped  out  1  sticky: input bin or frame_end discarded

Behaviour:
- Reset (rst low, async): state ACCUM; all sums, filtered regs and amp_out = 0; lv_start = 0; dropped = 0; lv_busy flag = 0.
- ACCUM:
  - On bin_valid, note = bin_idx mod BIN_QTY.
  - sum[note] <= min(sum[note] + bin_amp, 2^(W+D)-1), i.e. saturating.
  - bin_idx >= BIN_QTY*OCTAVES: ignored, dropped set.
  - frame_end -> FILTER. A bin_valid in the same cycle is included.
- FILTER: exactly BIN_QTY cycles, note i processed in the i-th cycle.
  - diff = sum[i] - filt[i], signed, W+D+1 bits.
  - filt[i] <= filt[i] + (diff >>> DECAY_SHIFT), arithmetic shift.
  - The result is clamped to [0, 2^(W+D)-1].
  - sum[i] <= 0 in the same cycle.
  - After note BIN_QTY-1 -> ISSUE.
- ISSUE:
  - If !lv_busy or lv_done this cycle: lv_start=1 for one cycle, amp_out <= filt (all lanes together), lv_busy <= 1, -> ACCUM.
  - Otherwise remain in ISSUE.
- Latency: frame_end at cycle t -> lv_start and new amp_out at cycle t+BIN_QTY+1 at the earliest.
- lv_busy: set on lv_start, cleared on lv_done. lv_done while not busy is ignored. lv_start and lv_done together leave lv_busy = 1.
- bin_valid or frame_end in FILTER/ISSUE: discarded, dropped set. Never corrupts the frame in flight.
- amp_out changes only in the lv_start cycle.
- dropped clears only on reset.
- Reset asserted mid-FILTER or mid-ISSUE: immediate return to reset values; no lv_start emitted.

Optional Feature:
- Macro PEAK_ATTACK_EN.
- Defined: in FILTER, if sum[i] > filt[i] then filt[i] <= sum[i] (instant attack); otherwise the IIR decay above applies.
- Undefined: symmetric IIR for both rise and fall.

Test Plan:
- Reset then frame with bin 3 = 1024 and bin 15 = 1024, frame_end -> sum[3] = 2048. lv_start at t+13 with amp_out[3] = 512, all other lanes 0. With PEAK_ATTACK_EN, amp_out[3] = 2048.
- Repeat the identical frame 3 times, lv_done returned between frames -> amp_out[3] = 512, 896, 1184.
- Bin 0 fed 65535 twice -> sum saturates at 65535, not 65534. Then 20 empty frames -> amp_out[0] decays monotonically, never negative.
- Hold lv_done low after first start, send next frame_end -> stays in ISSUE, no lv_start, amp_out unchanged. Pulse lv_done -> lv_start in that same cycle.
- bin_valid with bin_idx 60, plus bin_valid during FILTER -> dropped = 1; sums for valid bins unaffected.
- Assert rst in the 5th FILTER cycle -> all outputs 0 asynchronously; first post-reset frame behaves as in the first scenario.
